rtc_bus_write_cycle: RTL and testbench

Bus-cycle generator sitting directly downstream of the RTC write-sequencing state machine. It consumes that machine's write enable (`E_esc`) and registered address/data byte (`Dato_Dire`), and strobes `DIR`/`DAT` back to it to request the address byte and then the data byte. It drives one multiplexed address/data write cycle on the RTC's parallel bus, then pulses `cambio_estado` so the sequencer advances to its next register.

---
 rtl/rtc_bus_write_cycle.sv | 146 ++++++++++++++
 tb/tb_rtc_bus_write_cycle.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_write_cycle.sv
// Multiplexed address/data write-cycle generator for the RTC parallel bus.
// Requests the address and data bytes from the write sequencer, strobes them onto the bus, then reports completion.
module rtc_bus_write_cycle #(
    parameter int T_SETUP = 1,
    parameter int T_WR    = 2,
    parameter int T_HOLD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_esc,
    input  logic [7:0] Dato_Dire,
    output logic       DIR,
    output logic       DAT,
    output logic       cambio_estado,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        REQ_DIR,
        WAIT_DIR,
        A_SETUP,
        A_WR,
        A_HOLD,
        REQ_DAT,
        WAIT_DAT,
        D_SETUP,
        D_WR,
        D_HOLD,
        DONE,
        REARM
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
    localparam logic [7:0] WR_LAST    = 8'(T_WR - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(T_HOLD - 1);

    state_t     state, state_next;
    logic [7:0] phase_cnt, phase_cnt_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] data_reg, data_next;

    function automatic logic in_addr_phase(input state_t s);
        return (s == A_SETUP) || (s == A_WR) || (s == A_HOLD);
    endfunction

    function automatic logic in_data_phase(input state_t s);
        return (s == D_SETUP) || (s == D_WR) || (s == D_HOLD);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            phase_cnt <= 8'd0;
            addr_reg  <= 8'd0;
            data_reg  <= 8'd0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    // The phase counter restarts at zero in every state, so each timed state counts from its own entry.
    always_comb begin
        state_next     = state;
        phase_cnt_next = 8'd0;
        addr_next      = addr_reg;
        data_next      = data_reg;
        case (state)
            IDLE:     if (E_esc) state_next = REQ_DIR;
            REQ_DIR:  state_next = WAIT_DIR;
            WAIT_DIR: begin
                state_next = A_SETUP;
                addr_next  = Dato_Dire;
            end
            A_SETUP:  if (phase_cnt == SETUP_LAST) state_next = A_WR;
                      else phase_cnt_next = phase_cnt + 8'd1;
            A_WR:     if (phase_cnt == WR_LAST) state_next = A_HOLD;
                      else phase_cnt_next = phase_cnt + 8'd1;
            A_HOLD:   if (phase_cnt == HOLD_LAST) state_next = REQ_DAT;
                      else phase_cnt_next = phase_cnt + 8'd1;
            REQ_DAT:  state_next = WAIT_DAT;
            WAIT_DAT: begin
                state_next = D_SETUP;
                data_next  = Dato_Dire;
            end
            D_SETUP:  if (phase_cnt == SETUP_LAST) state_next = D_WR;
                      else phase_cnt_next = phase_cnt + 8'd1;
            D_WR:     if (phase_cnt == WR_LAST) state_next = D_HOLD;
                      else phase_cnt_next = phase_cnt + 8'd1;
            D_HOLD:   if (phase_cnt == HOLD_LAST) state_next = DONE;
                      else phase_cnt_next = phase_cnt + 8'd1;
            DONE:     state_next = REARM;
            REARM:    if (!E_esc) state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // Losing the enable mid-transaction abandons the cycle without a completion pulse.
        if (!E_esc && (state != IDLE) && (state != DONE) && (state != REARM)) begin
            state_next     = IDLE;
            phase_cnt_next = 8'd0;
        end
    end

    // Outputs are decoded from the next state and registered, keeping every output glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            DIR           <= 1'b0;
            DAT           <= 1'b0;
            cambio_estado <= 1'b0;
            cs_n          <= 1'b1;
            wr_n          <= 1'b1;
            a_d           <= 1'b1;
            ad_out        <= 8'h00;
            ad_oe         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            DIR           <= (state_next == REQ_DIR);
            DAT           <= (state_next == REQ_DAT);
            cambio_estado <= (state_next == DONE);
            cs_n          <= !(in_addr_phase(state_next) || in_data_phase(state_next));
            wr_n          <= !((state_next == A_WR) || (state_next == D_WR));
            a_d           <= !in_data_phase(state_next);
            ad_oe         <= in_addr_phase(state_next) || in_data_phase(state_next);
            busy          <= (state_next != IDLE);
            if (in_addr_phase(state_next)) begin
                ad_out <= addr_next;
            end else if (in_data_phase(state_next)) begin
                ad_out <= data_next;
            end else begin
                ad_out <= 8'h00;
            end
        end
    end

    assign rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_bus_write_cycle.sv
// Directed bench for rtc_bus_write_cycle: a default-timing instance and a stretched-timing instance,
// each answered by a small sequencer model that returns bytes on DIR/DAT.
module tb_rtc_bus_write_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset   = 1'b0;
    logic       e_esc_a = 1'b0, e_esc_b = 1'b0;
    logic [7:0] dato_a  = 8'h00, dato_b = 8'h00;
    logic       dir_a, dat_a, cam_a, cs_n_a, wr_n_a, rd_n_a, a_d_a, ad_oe_a, busy_a;
    logic       dir_b, dat_b, cam_b, cs_n_b, wr_n_b, rd_n_b, a_d_b, ad_oe_b, busy_b;
    logic [7:0] ad_out_a, ad_out_b;

    rtc_bus_write_cycle dut_a (
        .clk(clk), .reset(reset), .E_esc(e_esc_a), .Dato_Dire(dato_a),
        .DIR(dir_a), .DAT(dat_a), .cambio_estado(cam_a), .cs_n(cs_n_a), .wr_n(wr_n_a),
        .rd_n(rd_n_a), .a_d(a_d_a), .ad_out(ad_out_a), .ad_oe(ad_oe_a), .busy(busy_a)
    );

    rtc_bus_write_cycle #(.T_SETUP(3), .T_WR(5), .T_HOLD(2)) dut_b (
        .clk(clk), .reset(reset), .E_esc(e_esc_b), .Dato_Dire(dato_b),
        .DIR(dir_b), .DAT(dat_b), .cambio_estado(cam_b), .cs_n(cs_n_b), .wr_n(wr_n_b),
        .rd_n(rd_n_b), .a_d(a_d_b), .ad_out(ad_out_b), .ad_oe(ad_oe_b), .busy(busy_b)
    );

    logic       sel = 1'b0;
    logic [7:0] seq_addr = 8'h00, seq_data = 8'h00;

    // Sequencer model: answers a request strobe by updating its byte just after the edge ending that cycle.
    always @(posedge clk) begin
        if (dir_a) begin #1; dato_a = seq_addr; end
        else if (dat_a) begin #1; dato_a = seq_data; end
    end
    always @(posedge clk) begin
        if (dir_b) begin #1; dato_b = seq_addr; end
        else if (dat_b) begin #1; dato_b = seq_data; end
    end

    logic       o_dir, o_dat, o_cam, o_cs_n, o_wr_n, o_rd_n, o_a_d, o_ad_oe, o_busy;
    logic [7:0] o_ad_out;
    assign o_dir    = sel ? dir_b    : dir_a;
    assign o_dat    = sel ? dat_b    : dat_a;
    assign o_cam    = sel ? cam_b    : cam_a;
    assign o_cs_n   = sel ? cs_n_b   : cs_n_a;
    assign o_wr_n   = sel ? wr_n_b   : wr_n_a;
    assign o_rd_n   = sel ? rd_n_b   : rd_n_a;
    assign o_a_d    = sel ? a_d_b    : a_d_a;
    assign o_ad_oe  = sel ? ad_oe_b  : ad_oe_a;
    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_ad_out = sel ? ad_out_b : ad_out_a;

    localparam logic [31:0] RESET_VEC = 32'({3'b000, 4'b1111, 2'b00, 8'h00});

    function automatic logic [31:0] out_vec();
        return 32'({o_dir, o_dat, o_cam, o_cs_n, o_wr_n, o_rd_n, o_a_d, o_ad_oe, o_busy, o_ad_out});
    endfunction

    int n_pass  = 0;
    int n_total = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic set_e(input logic v);
        if (sel) e_esc_b = v;
        else     e_esc_a = v;
    endtask

    int dir_n, dir_first, dat_n, dat_first, cam_n, cam_first, bad_strobe, gap_hi;
    int aw_n, aw_first, aw_last, dw_n, dw_first, dw_last;
    logic [7:0]  aw_byte, dw_byte;
    logic        cs_hist   [0:63];
    logic        wr_hist   [0:63];
    logic        busy_hist [0:63];
    logic [31:0] vec_hist  [0:63];

    // Raises E_esc at a falling edge (cycle 0) and records cycles 1..n_cycles at each falling edge.
    task automatic applyStimulus(input int n_cycles, input int drop_cyc, input bit drop_on_cambio,
                                 input int rst_cyc);
        int cs_lo_first, cs_lo_last;
        dir_n = 0; dir_first = 0; dat_n = 0; dat_first = 0; cam_n = 0; cam_first = 0;
        aw_n = 0; aw_first = 0; aw_last = 0; dw_n = 0; dw_first = 0; dw_last = 0;
        aw_byte = 8'h00; dw_byte = 8'h00; bad_strobe = 0; gap_hi = 0;
        cs_lo_first = 0; cs_lo_last = 0;
        set_e(1'b1);
        for (int k = 1; k <= n_cycles; k++) begin
            @(negedge clk);
            cs_hist[k] = o_cs_n; wr_hist[k] = o_wr_n; busy_hist[k] = o_busy; vec_hist[k] = out_vec();
            if (o_dir) begin dir_n++; if (dir_first == 0) dir_first = k; end
            if (o_dat) begin dat_n++; if (dat_first == 0) dat_first = k; end
            if (o_cam) begin cam_n++; if (cam_first == 0) cam_first = k; end
            if (!o_cs_n) begin if (cs_lo_first == 0) cs_lo_first = k; cs_lo_last = k; end
            if (!o_wr_n) begin
                if (o_cs_n) bad_strobe++;
                if (o_a_d) begin
                    if (aw_n == 0) begin aw_first = k; aw_byte = o_ad_out; end
                    aw_n++; aw_last = k;
                end else begin
                    if (dw_n == 0) begin dw_first = k; dw_byte = o_ad_out; end
                    dw_n++; dw_last = k;
                end
            end
            if (drop_on_cambio && o_cam) set_e(1'b0);
            if (k == drop_cyc) set_e(1'b0);
            if (rst_cyc != 0 && k == rst_cyc) begin reset = 1'b0; set_e(1'b0); end
            if (rst_cyc != 0 && k == rst_cyc + 1) reset = 1'b1;
        end
        for (int k = cs_lo_first; k <= cs_lo_last; k++) if (k > 0 && cs_hist[k]) gap_hi++;
    endtask

    logic [7:0] full_addr [0:6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1};
    logic [7:0] full_data [0:6] = '{8'h30, 8'h59, 8'h12, 8'h07, 8'h11, 8'h24, 8'h01};
    int total_cam;

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        sel = 1'b0; checkOutput("reset_a", out_vec(), RESET_VEC);
        sel = 1'b1; checkOutput("reset_b", out_vec(), RESET_VEC);
        sel = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Default timing, single transaction.
        seq_addr = 8'h21; seq_data = 8'h45;
        applyStimulus(16, 0, 1'b1, 0);
        checkOutput("single_dir_cycle", dir_first, 1);
        checkOutput("single_dat_cycle", dat_first, 7);
        checkOutput("single_aw_first", aw_first, 4);
        checkOutput("single_aw_last", aw_last, 5);
        checkOutput("single_aw_byte", aw_byte, 8'h21);
        checkOutput("single_dw_first", dw_first, 10);
        checkOutput("single_dw_last", dw_last, 11);
        checkOutput("single_dw_byte", dw_byte, 8'h45);
        checkOutput("single_cam_cycle", cam_first, 13);
        checkOutput("single_cam_count", cam_n, 1);
        checkOutput("single_cs_gap", gap_hi, 2);
        checkOutput("single_wr_without_cs", bad_strobe, 0);
        checkOutput("single_rd_n", o_rd_n, 1);
        checkOutput("single_idle_after", busy_hist[16], 0);

        // Re-arm: E_esc stays high for 3 cycles past completion.
        seq_addr = 8'h33; seq_data = 8'h44;
        applyStimulus(16, 0, 1'b0, 0);
        checkOutput("rearm_cam_cycle", cam_first, 13);
        checkOutput("rearm_no_restart", dir_n, 1);
        checkOutput("rearm_held_busy", busy_hist[16], 1);
        set_e(1'b0);
        @(negedge clk);
        checkOutput("rearm_idle_busy", o_busy, 0);
        checkOutput("rearm_idle_dir", o_dir, 0);
        set_e(1'b1);
        @(negedge clk);
        checkOutput("rearm_dir_follows", o_dir, 1);
        set_e(1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rearm_abandon_idle", o_busy, 0);

        // Full seven-register sequence.
        total_cam = 0;
        for (int i = 0; i < 7; i++) begin
            seq_addr = full_addr[i]; seq_data = full_data[i];
            applyStimulus(16, 0, 1'b1, 0);
            total_cam += cam_n;
            checkOutput($sformatf("full_addr_%0d", i), aw_byte, full_addr[i]);
            checkOutput($sformatf("full_data_%0d", i), dw_byte, full_data[i]);
            checkOutput($sformatf("full_idle_%0d", i), busy_hist[16], 0);
        end
        checkOutput("full_cam_total", total_cam, 7);

        // Abort: enable dropped in the cycle after wr_n first falls.
        seq_addr = 8'h55; seq_data = 8'h66;
        applyStimulus(12, 5, 1'b0, 0);
        checkOutput("abort_wr_was_low", wr_hist[5], 0);
        checkOutput("abort_cs_n", cs_hist[6], 1);
        checkOutput("abort_wr_n", wr_hist[6], 1);
        checkOutput("abort_busy", busy_hist[6], 0);
        checkOutput("abort_no_dat", dat_n, 0);
        checkOutput("abort_no_cam", cam_n, 0);

        // Reset during D_WR, then a clean transaction.
        seq_addr = 8'h77; seq_data = 8'h88;
        applyStimulus(14, 0, 1'b0, 10);
        checkOutput("midreset_wr_low", wr_hist[10], 0);
        checkOutput("midreset_vec", vec_hist[11], RESET_VEC);
        checkOutput("midreset_no_cam", cam_n, 0);
        seq_addr = 8'h2A; seq_data = 8'h5C;
        applyStimulus(16, 0, 1'b1, 0);
        checkOutput("after_reset_cam", cam_first, 13);
        checkOutput("after_reset_addr", aw_byte, 8'h2A);
        checkOutput("after_reset_data", dw_byte, 8'h5C);

        // Stretched timing instance.
        sel = 1'b1;
        seq_addr = 8'hA5; seq_data = 8'h3C;
        applyStimulus(30, 0, 1'b1, 0);
        checkOutput("param_aw_first", aw_first, 6);
        checkOutput("param_aw_width", aw_n, 5);
        checkOutput("param_dw_first", dw_first, 18);
        checkOutput("param_dw_width", dw_n, 5);
        checkOutput("param_dat_cycle", dat_first, 13);
        checkOutput("param_cam_cycle", cam_first, 25);
        checkOutput("param_bytes", 32'({aw_byte, dw_byte}), 32'h0000A53C);
        checkOutput("param_idle_after", busy_hist[30], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
